// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FIFO depth, FSM states and
// the {pc, inst} entry carried from memory to decode.
package fetch_pkg;
  localparam int FETCH_DEPTH = 2;

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Two-entry in-order FIFO of fetched {pc, inst} pairs; head is read
// straight from the storage registers.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  fetch_entry_t pushData_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output fetch_entry_t head_o,
  output logic [1:0]   count_o
);
  fetch_entry_t mem_q [FETCH_DEPTH];
  logic         rdPtr_q;
  logic         wrPtr_q;
  logic [1:0]   count_q;
  logic         doPush;
  logic         doPop;

  assign doPop  = pop_i & (count_q != 2'd0);
  assign doPush = push_i & ((count_q != 2'(FETCH_DEPTH)) | doPop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FETCH_DEPTH; i++) mem_q[i] <= '0;
      rdPtr_q <= 1'b0;
      wrPtr_q <= 1'b0;
      count_q <= 2'd0;
    end else if (flush_i) begin
      rdPtr_q <= 1'b0;
      wrPtr_q <= 1'b0;
      count_q <= 2'd0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= pushData_i;
        wrPtr_q        <= ~wrPtr_q;
      end
      if (doPop) rdPtr_q <= ~rdPtr_q;
      count_q <= count_q + {1'b0, doPush} - {1'b0, doPop};
    end
  end

  assign head_o  = mem_q[rdPtr_q];
  assign count_o = count_q;
endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: issues word fetches from a PC register, buffers returned
// words in a 2-entry FIFO for decode, and flushes stale responses on redirect.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  input  logic        inst_ready_i
);
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [1:0]   outstanding_q, outstanding_d;
  logic [1:0]   discard_q, discard_d;

  logic [1:0]   fifoCount;
  fetch_entry_t fifoHead;
  fetch_entry_t pushEntry;
  logic         pop;
  logic         push;
  logic         grant;
  logic         rspLive;
  logic [2:0]   occupancy;

  assign inst_valid_o = (fifoCount != 2'd0);
  assign pop          = inst_valid_o & inst_ready_i;
  assign occupancy    = {1'b0, fifoCount} + {1'b0, outstanding_q} - {2'b00, pop};
  assign imem_req_o   = (state_q == RUN) & (occupancy < 3'(FETCH_DEPTH));
  assign imem_addr_o  = pc_q;
  assign grant        = imem_req_o & imem_gnt_i;
  assign rspLive      = imem_rvalid_i & (state_q == RUN) & (outstanding_q != 2'd0);
  assign push         = rspLive & ~redirect_i;

  // Outstanding requests are consecutive words ending just below pc_q, so the
  // oldest one (the one now responding) sits outstanding*4 bytes back.
  assign pushEntry.pc   = pc_q - {28'd0, outstanding_q, 2'b00};
  assign pushEntry.inst = imem_rdata_i;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    if (grant) pc_d = pc_q + 32'd4;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        outstanding_d = outstanding_q + {1'b0, grant} - {1'b0, rspLive};
        if (redirect_i) begin
          discard_d     = outstanding_d;
          outstanding_d = 2'd0;
          state_d       = (discard_d != 2'd0) ? FLUSH : RUN;
        end
      end
      FLUSH: begin
        if (imem_rvalid_i && (discard_q != 2'd0)) discard_d = discard_q - 2'd1;
        state_d = (discard_d == 2'd0) ? RUN : FLUSH;
      end
      default: state_d = BOOT;
    endcase
    if (redirect_i) pc_d = redirect_pc_i & ~32'h3;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= BOOT;
      pc_q          <= RESET_PC;
      outstanding_q <= 2'd0;
      discard_q     <= 2'd0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_fifo u_fifo (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .push_i     (push),
    .pushData_i (pushEntry),
    .pop_i      (pop),
    .flush_i    (redirect_i),
    .head_o     (fifoHead),
    .count_o    (fifoCount)
  );

  assign inst_o = fifoHead.inst;
  assign pc_o   = fifoHead.pc;
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, fetch address loaded at reset.
REQ-002 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port imem_req_o  output  1  fetch request valid.
REQ-005 SHALL have port imem_addr_o  output  32  fetch address, word-aligned.
REQ-006 SHALL have port imem_gnt_i  input  1  request accepted this cycle.
REQ-007 SHALL have port imem_rvalid_i  input  1  read data valid, in request order, latency >= 1 cycle after grant.
REQ-008 SHALL have port imem_rdata_i  input  32  instruction word.
REQ-009 SHALL have port redirect_i  input  1  branch/jump/trap redirect.
REQ-010 SHALL have port redirect_pc_i  input  32  redirect target; bits [1:0] ignored (treated as 0).
REQ-011 SHALL have port inst_valid_o  output  1  instruction available to decode.
REQ-012 SHALL have port inst_o  output  32  instruction word to decode/immediate generation.
REQ-013 SHALL have port pc_o  output  32  address of inst_o.
REQ-014 SHALL have port inst_ready_i  input  1  decode accepts; low = decode stall.

Function
REQ-015 SHALL hold a PC register; each grant (imem_req_o & imem_gnt_i) SHALL advance PC by 4, wrapping 32'hFFFF_FFFC -> 0.
REQ-016 SHALL keep imem_req_o and imem_addr_o stable until granted, except on redirect.
REQ-017 SHALL buffer returned {pc, inst} pairs in a 2-entry in-order FIFO; inst_valid_o = FIFO non-empty; inst_o/pc_o = FIFO head, driven from registers.
REQ-018 SHALL pop the head when inst_valid_o & inst_ready_i; inst_o/pc_o SHALL stay stable while inst_valid_o & !inst_ready_i.
REQ-019 SHALL count outstanding granted requests (0..2) and assert imem_req_o in RUN only when fifo_count + outstanding - pop < 2, giving sustained one instruction per cycle with gnt=1, 1-cycle memory latency, ready=1.
REQ-020 SHALL write a response into the FIFO on imem_rvalid_i; data visible on inst_o the cycle after rvalid; no overflow possible by REQ-019.
REQ-021 SHALL implement FSM states BOOT, RUN, FLUSH: BOOT -> RUN after first clock following reset release; RUN -> FLUSH on redirect with in-flight requests (including one granted same cycle); FLUSH -> RUN when discard count reaches 0; RUN -> RUN on redirect with none in flight.
REQ-022 On redirect_i SHALL, next cycle: PC = redirect_pc_i & ~3, FIFO emptied, discard count = in-flight requests; an ungranted pending request SHALL be withdrawn.
REQ-023 In FLUSH SHALL keep imem_req_o low and drop each imem_rvalid_i response, decrementing discard count.
REQ-024 rvalid in the same cycle as redirect_i SHALL be discarded; a pop in the same cycle as redirect_i SHALL complete normally.
REQ-025 Redirect during FLUSH SHALL update PC and remain in FLUSH with discard count unchanged except for rvalid that cycle.

Reset
REQ-026 On rst_ni low, immediately: state BOOT, PC = RESET_PC, FIFO empty, counters 0, imem_req_o = 0, inst_valid_o = 0, imem_addr_o = RESET_PC, inst_o = 0, pc_o = 0.
REQ-027 Reset asserted mid-transfer SHALL abandon all in-flight requests; responses arriving after reset release with outstanding=0 SHALL be ignored.

Structure
REQ-028 Package fetch_pkg SHALL hold FETCH_DEPTH = 2, state enum {BOOT, RUN, FLUSH}, and struct fetch_entry_t {pc[31:0], inst[31:0]}.
REQ-029 SHALL instantiate one sub-module fetch_fifo (2-entry, push/pop/flush, count output) storing fetch_entry_t.

Verification
REQ-030 Reset release, gnt=1, latency 1, ready=1 -> addresses 0,4,8,12 on consecutive cycles; inst_valid_o from cycle 3 with pc_o 0,4,8, one per cycle.
REQ-031 ready=0 for 5 cycles after first instruction -> at most 2 requests granted, inst_o/pc_o held at pc 0, no loss after ready=1.
REQ-032 Redirect to 32'h0000_0103 with 2 in flight -> FLUSH, 2 responses dropped, next request addr 32'h0000_0100, next pc_o 32'h0000_0100.
REQ-033 gnt=0 for 3 cycles -> imem_addr_o held at same value, PC not advanced; redirect during that wait -> address changes to target next cycle.
REQ-034 PC at 32'hFFFF_FFFC granted -> next imem_addr_o 32'h0000_0000.
REQ-035 rst_ni low with FIFO full and 2 outstanding -> outputs per REQ-026 same cycle; fetch restarts at RESET_PC.
